// File: rtl/ascensor_pkg.sv
// Shared elevator definitions: direction codes used by the LED block and the
// dispatcher, plus the car sequencer state encoding.
package ascensor_pkg;

    localparam logic [1:0] DIR_NADA  = 2'b00;
    localparam logic [1:0] DIR_SUBIR = 2'b01;
    localparam logic [1:0] DIR_BAJAR = 2'b10;

    typedef enum logic [1:0] {
        REPOSO,
        SUBIENDO,
        BAJANDO,
        PUERTAS
    } estado_t;

    typedef enum logic {
        SUBIR,
        BAJAR
    } sentido_t;

    function automatic logic [1:0] dir_de(estado_t e);
        case (e)
            SUBIENDO: dir_de = DIR_SUBIR;
            BAJANDO:  dir_de = DIR_BAJAR;
            default:  dir_de = DIR_NADA;
        endcase
    endfunction

endpackage

// File: rtl/controlador_ascensor_if.sv
// Request/status bundle between a car sequencer and its requester/consumers.
interface controlador_ascensor_if #(
    parameter int NUM_PISOS = 4,
    parameter int W_PISO    = $clog2(NUM_PISOS)
);
    logic [NUM_PISOS-1:0] solicitud;
    logic [W_PISO-1:0]    piso_actual;
    logic [1:0]           direccion;
    logic                 puertas_abiertas;
    logic [NUM_PISOS-1:0] pendientes;

    modport master (
        output solicitud,
        input  piso_actual, direccion, puertas_abiertas, pendientes
    );

    modport slave (
        input  solicitud,
        output piso_actual, direccion, puertas_abiertas, pendientes
    );
endinterface

// File: rtl/temporizador.sv
// Up-counter with load of a terminal value; saturates at the terminal count.
module temporizador #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         carga,
    input  logic [W-1:0] limite,
    input  logic         habilitar,
    output logic         fin
);
    logic [W-1:0] cuenta;
    logic [W-1:0] lim;

    assign fin = (cuenta == lim);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cuenta <= '0;
            lim    <= '0;
        end else if (carga) begin
            cuenta <= '0;
            lim    <= limite;
        end else if (habilitar && !fin) begin
            cuenta <= cuenta + W'(1);
        end
    end
endmodule

// File: rtl/controlador_ascensor.sv
// Per-car sequencer: latches floor calls, moves one floor at a time with a
// collective-selective policy and holds the doors open at served floors.
module controlador_ascensor
    import ascensor_pkg::*;
#(
    parameter int NUM_PISOS    = 4,
    parameter int TICKS_PISO   = 100,
    parameter int TICKS_PUERTA = 200,
    parameter int W_PISO       = $clog2(NUM_PISOS)
) (
    input logic                   clk,
    input logic                   rst_n,
    controlador_ascensor_if.slave bus
);
    localparam int T_MAX = (TICKS_PISO > TICKS_PUERTA) ? TICKS_PISO : TICKS_PUERTA;
    localparam int W_T   = (T_MAX > 1) ? $clog2(T_MAX) : 1;
    localparam logic [W_T-1:0]    LIM_PISO   = W_T'(TICKS_PISO - 1);
    localparam logic [W_T-1:0]    LIM_PUERTA = W_T'(TICKS_PUERTA - 1);
    localparam logic [W_PISO-1:0] PISO_TOPE  = W_PISO'(NUM_PISOS - 1);

    estado_t              estado, estado_n;
    sentido_t             sentido, sentido_n;
    logic [W_PISO-1:0]    piso_n, piso_sig, piso_ant;
    logic [NUM_PISOS-1:0] req, clr, pend_n;
    logic                 arriba, abajo, aqui;
    logic                 carga, fin;
    logic [W_T-1:0]       limite;

    function automatic logic hay_en(logic [NUM_PISOS-1:0] r, logic [W_PISO-1:0] p, logic sube);
        hay_en = 1'b0;
        for (int unsigned i = 0; i < NUM_PISOS; i++)
            if (sube ? (i > 32'(p)) : (i < 32'(p)))
                hay_en = hay_en | r[i];
    endfunction

    temporizador #(.W(W_T)) u_temporizador (
        .clk       (clk),
        .rst_n     (rst_n),
        .carga     (carga),
        .limite    (limite),
        .habilitar (estado != REPOSO),
        .fin       (fin)
    );

    always_comb begin
        req       = bus.pendientes | bus.solicitud;
        arriba    = hay_en(req, bus.piso_actual, 1'b1);
        abajo     = hay_en(req, bus.piso_actual, 1'b0);
        aqui      = req[bus.piso_actual];
        piso_sig  = bus.piso_actual + W_PISO'(1);
        piso_ant  = bus.piso_actual - W_PISO'(1);
        estado_n  = estado;
        sentido_n = sentido;
        piso_n    = bus.piso_actual;
        carga     = 1'b0;

        case (estado)
            REPOSO: begin
                carga = 1'b1;
                if (aqui) begin
                    estado_n = PUERTAS;
                end else if (arriba) begin
                    estado_n  = SUBIENDO;
                    sentido_n = SUBIR;
                end else if (abajo) begin
                    estado_n  = BAJANDO;
                    sentido_n = BAJAR;
                end
            end
            SUBIENDO: if (fin) begin
                carga = 1'b1;
                // at the top floor the car can only stop, never step further
                if (bus.piso_actual == PISO_TOPE) begin
                    estado_n = aqui ? PUERTAS : REPOSO;
                end else begin
                    piso_n = piso_sig;
                    if (req[piso_sig])                    estado_n = PUERTAS;
                    else if (!hay_en(req, piso_sig, 1'b1)) estado_n = REPOSO;
                end
            end
            BAJANDO: if (fin) begin
                carga = 1'b1;
                if (bus.piso_actual == '0) begin
                    estado_n = aqui ? PUERTAS : REPOSO;
                end else begin
                    piso_n = piso_ant;
                    if (req[piso_ant])                    estado_n = PUERTAS;
                    else if (!hay_en(req, piso_ant, 1'b0)) estado_n = REPOSO;
                end
            end
            PUERTAS: begin
                if (bus.solicitud[bus.piso_actual]) begin
                    carga = 1'b1;
                end else if (fin) begin
                    carga = 1'b1;
                    if (sentido == SUBIR) begin
                        if (arriba)     estado_n = SUBIENDO;
                        else if (abajo) begin
                            estado_n  = BAJANDO;
                            sentido_n = BAJAR;
                        end else        estado_n = REPOSO;
                    end else begin
                        if (abajo)       estado_n = BAJANDO;
                        else if (arriba) begin
                            estado_n  = SUBIENDO;
                            sentido_n = SUBIR;
                        end else         estado_n = REPOSO;
                    end
                end
            end
            default: estado_n = REPOSO;
        endcase

        limite = (estado_n == PUERTAS) ? LIM_PUERTA : LIM_PISO;
        // clear the destination floor so a served call never lingers
        clr = '0;
        if (estado_n == PUERTAS) clr[piso_n] = 1'b1;
        pend_n = req & ~clr;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado               <= REPOSO;
            sentido              <= SUBIR;
            bus.piso_actual      <= '0;
            bus.direccion        <= DIR_NADA;
            bus.puertas_abiertas <= 1'b0;
            bus.pendientes       <= '0;
        end else begin
            estado               <= estado_n;
            sentido              <= sentido_n;
            bus.piso_actual      <= piso_n;
            bus.direccion        <= dir_de(estado_n);
            bus.puertas_abiertas <= (estado_n == PUERTAS);
            bus.pendientes       <= pend_n;
        end
    end
endmodule
